// File: rtl/block_packer_if.sv
// Byte-in / block-out handshake bundle for block_packer.
// slave modport is the packer's view; master modport is the producer/consumer view.
interface block_packer_if #(
    parameter int BLOCK_BYTES = 16
);
    logic [7:0]               in_data;
    logic                     in_valid;
    logic                     in_last;
    logic                     in_ready;
    logic [8*BLOCK_BYTES-1:0] out_block;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_last;
    logic [6:0]               last_size;
    logic                     no_bytes;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_block, out_valid, out_last, last_size, no_bytes
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_block, out_valid, out_last, last_size, no_bytes
    );
endinterface

// File: rtl/block_packer.sv
// Packs a byte stream into BLOCK_BYTES-wide blocks for the AES datapath; BLOCK_PACKER_PAD_EN selects PKCS#7 padding.
// Latency: block valid the cycle after its last byte is accepted (all outputs registered).
// Backpressure: in_ready drops while a block is held; a held block stays stable until out_ready.
module block_packer #(
    parameter int BLOCK_BYTES = 16
) (
    input  logic          clk,
    input  logic          n_rst,
    block_packer_if.slave bus
);
    localparam int CW = $clog2(BLOCK_BYTES) + 1;
    localparam int BW = 8 * BLOCK_BYTES;

    typedef enum logic [1:0] {FILL, HOLD, PAD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [BW-1:0] block_q, block_d;
    logic          last_q, last_d;
    logic          nb_q, nb_d;
    logic [6:0]    ls_q, ls_d;
    logic          full;
`ifdef BLOCK_PACKER_PAD_EN
    logic          pad_pend_q, pad_pend_d;
    logic [7:0]    pad_val;

    assign pad_val = 8'(BLOCK_BYTES) - 8'(count_q) - 8'd1;
`endif

    assign full = (count_q == CW'(BLOCK_BYTES - 1));

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        block_d = block_q;
        last_d  = last_q;
        nb_d    = nb_q;
        ls_d    = ls_q;
`ifdef BLOCK_PACKER_PAD_EN
        pad_pend_d = pad_pend_q;
`endif
        case (state_q)
            FILL: begin
                if (bus.in_valid) begin
                    // Byte 0 wipes stale lanes so short blocks carry zeros above the data.
                    for (int i = 0; i < BLOCK_BYTES; i++) begin
                        if (CW'(i) == count_q) begin
                            block_d[8*i +: 8] = bus.in_data;
                        end else if (count_q == '0) begin
                            block_d[8*i +: 8] = 8'h00;
                        end
`ifdef BLOCK_PACKER_PAD_EN
                        if (bus.in_last && (CW'(i) > count_q)) begin
                            block_d[8*i +: 8] = pad_val;
                        end
`endif
                    end
                    count_d = count_q + 1'b1;
                    if (full || bus.in_last) begin
                        state_d = HOLD;
                        last_d  = bus.in_last;
`ifdef BLOCK_PACKER_PAD_EN
                        nb_d = 1'b0;
                        ls_d = 7'd0;
                        // A message ending on a boundary still owes a full pad block.
                        if (full && bus.in_last) begin
                            last_d     = 1'b0;
                            pad_pend_d = 1'b1;
                        end
`else
                        nb_d = !full;
                        ls_d = full ? 7'd0 : 7'({count_d, 3'b000});
`endif
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = FILL;
                    count_d = '0;
                    last_d  = 1'b0;
                    nb_d    = 1'b0;
                    ls_d    = 7'd0;
`ifdef BLOCK_PACKER_PAD_EN
                    if (pad_pend_q) begin
                        state_d    = PAD;
                        pad_pend_d = 1'b0;
                        last_d     = 1'b1;
                        for (int i = 0; i < BLOCK_BYTES; i++) begin
                            block_d[8*i +: 8] = 8'(BLOCK_BYTES);
                        end
                    end
`endif
                end
            end
            PAD: begin
                if (bus.out_ready) begin
                    state_d = FILL;
                    count_d = '0;
                    last_d  = 1'b0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= FILL;
            count_q <= '0;
            block_q <= '0;
            last_q  <= 1'b0;
            nb_q    <= 1'b0;
            ls_q    <= 7'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            block_q <= block_d;
            last_q  <= last_d;
            nb_q    <= nb_d;
            ls_q    <= ls_d;
        end
    end

`ifdef BLOCK_PACKER_PAD_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pad_pend_q <= 1'b0;
        end else begin
            pad_pend_q <= pad_pend_d;
        end
    end
`endif

    assign bus.in_ready  = (state_q == FILL);
    assign bus.out_valid = (state_q != FILL);
    assign bus.out_block = block_q;
    assign bus.out_last  = last_q;
    assign bus.no_bytes  = nb_q;
    assign bus.last_size = ls_q;
endmodule

// File: tb/tb_block_packer.sv
// Self-checking bench for block_packer: reset, latency, table vectors, backpressure, mid-block reset, random traffic.
module tb_block_packer;
    localparam int BB = 16;
    localparam int BW = 8 * BB;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [BW-1:0] blk;
        logic          last;
        logic          nb;
        logic [6:0]    ls;
    } rec_t;
    typedef struct {
        int          len;
        logic [7:0]  start;
        int          blocks;
        logic        nb;
        logic [6:0]  ls;
        logic [31:0] lo32;
        logic [7:0]  top8;
    } vec_t;

    logic clk = 1'b0;
    logic n_rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   rdy_mode = 1;
    rec_t rx_q[$];
    rec_t exp_q[$];

    block_packer_if #(.BLOCK_BYTES(BB)) bus ();
    block_packer #(.BLOCK_BYTES(BB)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

    always #5 clk = ~clk;

    // Sole driver of out_ready: 0 = held low, 1 = held high, other = random.
    initial forever begin
        case (rdy_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = ($urandom_range(0, 3) != 0);
        endcase
        @(posedge clk);
        #1;
    end

    always @(negedge clk) begin
        if (n_rst && bus.out_valid && bus.out_ready)
            rx_q.push_back('{bus.out_block, bus.out_last, bus.no_bytes, bus.last_size});
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected blocks derived straight from message length and byte values.
    function automatic void model(input bq_t msg);
        int len;
        int nblk;
        int k;
        rec_t r;
        len  = msg.size();
        nblk = (len + BB - 1) / BB;
        for (int b = 0; b < nblk; b++) begin
            k      = (len - b * BB < BB) ? (len - b * BB) : BB;
            r.blk  = '0;
            r.last = (b == nblk - 1);
            for (int j = 0; j < k; j++) r.blk[8*j +: 8] = msg[b * BB + j];
`ifdef BLOCK_PACKER_PAD_EN
            for (int j = k; j < BB; j++) r.blk[8*j +: 8] = 8'(BB - k);
            r.nb = 1'b0;
            r.ls = 7'd0;
            if (r.last && k == BB) begin
                r.last = 1'b0;
                exp_q.push_back(r);
                for (int j = 0; j < BB; j++) r.blk[8*j +: 8] = 8'(BB);
                r.last = 1'b1;
            end
`else
            r.nb = (k < BB);
            r.ls = (k < BB) ? 7'(8 * k) : 7'd0;
`endif
            exp_q.push_back(r);
        end
    endfunction

    // Called and returns just after a rising edge.
    task automatic send_msg(input bq_t msg, input bit gaps, input bit mark_last);
        logic r;
        int   c;
        for (int i = 0; i < msg.size(); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.in_valid = 1'b0;
                    bus.in_last  = 1'b0;
                    bus.in_data  = 8'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
            bus.in_valid = 1'b1;
            bus.in_data  = msg[i];
            bus.in_last  = mark_last && (i == msg.size() - 1);
            c = 0;
            r = 1'b0;
            while (!r && c < 2000) begin
                @(negedge clk);
                r = bus.in_ready;
                @(posedge clk);
                #1;
                c++;
            end
            if (!r) begin
                n_cmp++;
                n_err++;
                $display("FAIL send_timeout: byte %0d never accepted", i);
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = 8'($urandom);
    endtask

    task automatic wait_rx(input int n);
        int c = 0;
        while (rx_q.size() < n && c < 1000) begin
            @(negedge clk);
            c++;
        end
        chk("rx_wait", BW'(rx_q.size() >= n), BW'(1));
    endtask

    task automatic check_rx(input string nm);
        rec_t a;
        rec_t e;
        wait_rx(exp_q.size());
        repeat (3) @(negedge clk);
        chk({nm, "_count"}, BW'(rx_q.size()), BW'(exp_q.size()));
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            a = rx_q.pop_front();
            e = exp_q.pop_front();
            chk({nm, "_block"}, a.blk, e.blk);
            chk({nm, "_last"}, BW'(a.last), BW'(e.last));
            chk({nm, "_no_bytes"}, BW'(a.nb), BW'(e.nb));
            chk({nm, "_last_size"}, BW'(a.ls), BW'(e.ls));
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        bq_t  m;
        vec_t vt[7];
        int   c;
        logic [BW-1:0] held;

        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = 8'h00;
        #2 n_rst = 1'b0;
        #10;
        chk("rst_in_ready", BW'(bus.in_ready), BW'(1));
        chk("rst_out_valid", BW'(bus.out_valid), BW'(0));
        chk("rst_out_last", BW'(bus.out_last), BW'(0));
        chk("rst_last_size", BW'(bus.last_size), BW'(0));
        chk("rst_no_bytes", BW'(bus.no_bytes), BW'(0));
        chk("rst_out_block", bus.out_block, BW'(0));
        @(posedge clk);
        #1 n_rst = 1'b1;
        @(posedge clk);
        #1;

        // Registered latency: valid appears the cycle after the final byte.
        m = '{8'h5A};
        model(m);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        bus.in_last  = 1'b1;
        @(negedge clk);
        chk("lat_pre_valid", BW'(bus.out_valid), BW'(0));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        @(negedge clk);
        chk("lat_valid", BW'(bus.out_valid), BW'(1));
        chk("lat_in_ready", BW'(bus.in_ready), BW'(0));
        chk("lat_block", bus.out_block, exp_q[0].blk);
        check_rx("lat");
        @(posedge clk);
        #1;

`ifndef BLOCK_PACKER_PAD_EN
        vt[0] = '{16, 8'h00, 1, 1'b0, 7'd0,   32'h03020100, 8'h0F};
        vt[1] = '{5,  8'hA1, 1, 1'b1, 7'd40,  32'hA4A3A2A1, 8'h00};
        vt[2] = '{1,  8'h77, 1, 1'b1, 7'd8,   32'h00000077, 8'h00};
        vt[3] = '{17, 8'h10, 2, 1'b1, 7'd8,   32'h00000020, 8'h00};
        vt[4] = '{32, 8'h00, 2, 1'b0, 7'd0,   32'h13121110, 8'h1F};
        vt[5] = '{31, 8'h00, 2, 1'b1, 7'd120, 32'h13121110, 8'h00};
        vt[6] = '{20, 8'hC0, 2, 1'b1, 7'd32,  32'hD3D2D1D0, 8'h00};
        rdy_mode = 1;
        for (int t = 0; t < 7; t++) begin
            m.delete();
            for (int i = 0; i < vt[t].len; i++) m.push_back(8'(vt[t].start + 8'(i)));
            model(m);
            send_msg(m, 1'b0, 1'b1);
            wait_rx(vt[t].blocks);
            repeat (2) @(negedge clk);
            chk("vec_blocks", BW'(rx_q.size()), BW'(vt[t].blocks));
            if (rx_q.size() > 0) begin
                chk("vec_lo32", BW'(rx_q[$].blk[31:0]), BW'(vt[t].lo32));
                chk("vec_top8", BW'(rx_q[$].blk[BW-1 -: 8]), BW'(vt[t].top8));
                chk("vec_no_bytes", BW'(rx_q[$].nb), BW'(vt[t].nb));
                chk("vec_last_size", BW'(rx_q[$].ls), BW'(vt[t].ls));
                chk("vec_out_last", BW'(rx_q[$].last), BW'(1));
            end
            check_rx("vec");
            @(posedge clk);
            #1;
        end
`else
        rdy_mode = 1;
        m = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        model(m);
        send_msg(m, 1'b0, 1'b1);
        wait_rx(1);
        if (rx_q.size() > 0) begin
            chk("pad5_block", rx_q[0].blk, 128'h0B0B0B0B0B0B0B0B0B0B0BA5A4A3A2A1);
            chk("pad5_no_bytes", BW'(rx_q[0].nb), BW'(0));
        end
        check_rx("pad5");
        @(posedge clk);
        #1;
        m.delete();
        for (int i = 0; i < 16; i++) m.push_back(8'(i));
        model(m);
        send_msg(m, 1'b0, 1'b1);
        wait_rx(2);
        if (rx_q.size() > 1) begin
            chk("pad16_data_last", BW'(rx_q[0].last), BW'(0));
            chk("pad16_pad_block", rx_q[1].blk, 128'h10101010101010101010101010101010);
            chk("pad16_pad_last", BW'(rx_q[1].last), BW'(1));
        end
        check_rx("pad16");
        @(posedge clk);
        #1;
`endif

        // Backpressure: first block held for 10 cycles while the producer keeps offering.
        rdy_mode = 0;
        m.delete();
        for (int i = 0; i < 20; i++) m.push_back(8'(8'h40 + 8'(i)));
        model(m);
        fork
            send_msg(m, 1'b0, 1'b1);
        join_none
        c = 0;
        while (!bus.out_valid && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("bp_valid", BW'(bus.out_valid), BW'(1));
        held = exp_q[0].blk;
        repeat (10) begin
            @(negedge clk);
            chk("bp_block_stable", bus.out_block, held);
            chk("bp_in_ready", BW'(bus.in_ready), BW'(0));
            chk("bp_out_valid", BW'(bus.out_valid), BW'(1));
        end
        rdy_mode = 1;
        wait fork;
        check_rx("bp");
        @(posedge clk);
        #1;

        // Reset mid-block: partial data must vanish.
        m.delete();
        for (int i = 0; i < 7; i++) m.push_back(8'(8'h90 + 8'(i)));
        send_msg(m, 1'b0, 1'b0);
        n_rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", BW'(bus.out_valid), BW'(0));
        chk("mid_rst_block", bus.out_block, BW'(0));
        @(posedge clk);
        #1 n_rst = 1'b1;
        @(posedge clk);
        #1;
        m = '{8'h3C};
        model(m);
        send_msg(m, 1'b0, 1'b1);
        check_rx("mid_rst");
        @(posedge clk);
        #1;

        rdy_mode = 2;
        for (int t = 0; t < 40; t++) begin
            m.delete();
            c = $urandom_range(1, 40);
            for (int i = 0; i < c; i++) m.push_back(8'($urandom));
            model(m);
            send_msg(m, 1'b1, 1'b1);
            check_rx("rand");
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
